// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the sequential ALU and its iterative engine:
//   function codes, the top-level FSM state type, the engine mode type and
//   the bit positions of the packed flag register.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  // Function codes. b is the destination operand, a is the source/count.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SHL   = 4'b0101;
  localparam logic [3:0] ALU_SHR   = 4'b0110;
  localparam logic [3:0] ALU_NOT   = 4'b0111;
  localparam logic [3:0] ALU_DIV   = 4'b1000;
  localparam logic [3:0] ALU_MUL   = 4'b1001;
  localparam logic [3:0] ALU_ROL   = 4'b1010;
  localparam logic [3:0] ALU_ROR   = 4'b1011;
  localparam logic [3:0] ALU_ASR   = 4'b1100;
  localparam logic [3:0] ALU_BREV  = 4'b1101;
  localparam logic [3:0] ALU_BSWAP = 4'b1110;
  localparam logic [3:0] ALU_CLR   = 4'b1111;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // Operation carried out by the shared multiply/divide engine.
  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } iter_mode_t;

  // Bit positions inside the packed flag register.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

endpackage

// File: rtl/seq_alu_iter.sv
// -----------------------------------------------------------------------------
// seq_alu_iter
//   Shared iterative engine: unsigned shift-add multiply or restoring divide,
//   one bit per cycle for WIDTH cycles after a start pulse.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load operands and begin (one cycle)
//   mode           MODE_MUL: product = b * a ; MODE_DIV: b / a
//   a, b           source / destination operands, sampled on start
//   done           high during the last (WIDTH-th) iteration cycle
//   res_lo/res_hi  value the engine holds after the current step; on the
//                  done cycle this is product[W-1:0]/product[2W-1:W] or
//                  quotient/remainder
// -----------------------------------------------------------------------------
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic             busy;
  iter_mode_t       mode_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // One step of either algorithm. For multiply {hi,lo} is the partial
  // product with the unused multiplier bits in lo; for divide hi is the
  // partial remainder and lo shifts the dividend out / quotient in.
  // A zero divisor always "fits", which naturally yields an all-ones
  // quotient and the dividend as remainder.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, opnd});
    trial   = shifted[WIDTH-1:0] - opnd;
    if (mode_q == MODE_MUL) begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nxt = fits ? trial : shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], fits};
    end
  end

  assign done   = busy && (cnt == CW'(WIDTH - 1));
  assign res_lo = lo_nxt;
  assign res_hi = hi_nxt;

  // Operand load and the WIDTH-cycle iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      mode_q <= MODE_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= '0;
      hi     <= '0;
      if (mode == MODE_MUL) begin
        lo   <= a;
        opnd <= b;
      end else begin
        lo   <= b;
        opnd <= a;
      end
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Registered multi-cycle ALU with a valid/ready request handshake.
//   Single-cycle ops produce out_valid one cycle after acceptance; MUL and
//   DIV run WIDTH iterations in seq_alu_iter and report WIDTH+1 cycles after.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake; captured when both are high
//   func, cin, a, b   operation code, carry/borrow in, source, destination
//   out_valid         one-cycle pulse marking result/flags valid
//   result            primary result
//   result_hi         MUL high product half, DIV remainder, else 0
//   c, z, v, s        carry, zero, overflow, sign (held until next result)
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c,
  output logic             z,
  output logic             v,
  output logic             s
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             iter_start;
  iter_mode_t       iter_mode;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic             div_zero;

  logic [SHW-1:0]   n;
  logic [WIDTH:0]   wide;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;

  logic             load;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] hi_nxt;
  logic             c_sel;
  logic             v_sel;
  logic [3:0]       flags_nxt;
  logic [3:0]       flags;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && ((func == ALU_MUL) || (func == ALU_DIV));
  assign iter_mode  = (func == ALU_DIV) ? MODE_DIV : MODE_MUL;
  assign n          = a[SHW-1:0];

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .mode   (iter_mode),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .res_lo (iter_lo),
    .res_hi (iter_hi)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: long ops park in MUL/DIV until the engine's last step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (func == ALU_MUL)      state_nxt = ST_MUL;
          else if (func == ALU_DIV) state_nxt = ST_DIV;
          else                      state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_done) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated on the operands being accepted.
  // Shifts are done one bit wider so the last bit shifted out falls into
  // the extra position and is 0 for a zero count.
  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    wide   = '0;
    dbl    = '0;
    case (func)
      ALU_ADD: begin
        wide   = {1'b0, b} + {1'b0, a} + {{WIDTH{1'b0}}, cin};
        op_res = wide[WIDTH-1:0];
        op_c   = wide[WIDTH];
        op_v   = (b[WIDTH-1] == a[WIDTH-1]) && (wide[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_SUB: begin
        wide   = {1'b0, b} - {1'b0, a} - {{WIDTH{1'b0}}, cin};
        op_res = wide[WIDTH-1:0];
        op_c   = wide[WIDTH];
        op_v   = (b[WIDTH-1] != a[WIDTH-1]) && (wide[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: op_res = b & a;
      ALU_OR:  op_res = b | a;
      ALU_XOR: op_res = b ^ a;
      ALU_SHL: begin
        wide   = {1'b0, b} << n;
        op_res = wide[WIDTH-1:0];
        op_c   = wide[WIDTH];
      end
      ALU_SHR: begin
        wide   = {b, 1'b0} >> n;
        op_res = wide[WIDTH:1];
        op_c   = wide[0];
      end
      ALU_ASR: begin
        wide   = $signed({b, 1'b0}) >>> n;
        op_res = wide[WIDTH:1];
        op_c   = wide[0];
      end
      ALU_NOT: op_res = ~b;
      ALU_ROL: begin
        dbl    = {b, b} << n;
        op_res = dbl[2*WIDTH-1:WIDTH];
      end
      ALU_ROR: begin
        dbl    = {b, b} >> n;
        op_res = dbl[WIDTH-1:0];
      end
      ALU_BREV: begin
        for (int i = 0; i < WIDTH; i++) begin
          op_res[i] = b[WIDTH-1-i];
        end
      end
      ALU_BSWAP: begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          op_res[8*i +: 8] = b[WIDTH-8-8*i +: 8];
        end
      end
      default: op_res = '0;
    endcase
  end

  // Divide-by-zero is remembered from the accepted divisor; the engine
  // itself produces the all-ones quotient and dividend remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero <= 1'b0;
    end else if (accept && (func == ALU_DIV)) begin
      div_zero <= (a == '0);
    end
  end

  // Select what gets registered on entry to DONE and derive the flags from
  // that same value.
  always_comb begin
    res_nxt = op_res;
    hi_nxt  = '0;
    c_sel   = op_c;
    v_sel   = op_v;
    if (state == ST_MUL) begin
      res_nxt = iter_lo;
      hi_nxt  = iter_hi;
      c_sel   = 1'b0;
      v_sel   = (iter_hi != '0);
    end else if (state == ST_DIV) begin
      res_nxt = iter_lo;
      hi_nxt  = iter_hi;
      c_sel   = 1'b0;
      v_sel   = div_zero;
    end
    flags_nxt         = '0;
    flags_nxt[FLAG_C] = c_sel;
    flags_nxt[FLAG_Z] = (res_nxt == '0);
    flags_nxt[FLAG_V] = v_sel;
    flags_nxt[FLAG_S] = res_nxt[WIDTH-1];
  end

  assign load = (accept && !iter_start) ||
                (((state == ST_MUL) || (state == ST_DIV)) && iter_done);

  // Result and flag registers hold until the next completed operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (load) begin
      result    <= res_nxt;
      result_hi <= hi_nxt;
      flags     <= flags_nxt;
    end
  end

  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign s = flags[FLAG_S];

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu at WIDTH=16 and WIDTH=32. Expected
//   values come from directed constants and from an arithmetic reference
//   model operating on 64-bit integers.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  typedef longint unsigned u64_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        c;
    logic        z;
    logic        v;
    logic        s;
  } obs_t;

  typedef struct packed {
    logic [3:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] res;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        v;
    logic        s;
    logic [7:0]  lat;
  } vec_t;

  localparam int NVEC = 18;
  localparam vec_t VECS [NVEC] = '{
    '{4'h0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'h1, 16'h0001, 16'h8000, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
    '{4'h1, 16'h0005, 16'h0003, 1'b1, 16'hFFFD, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
    '{4'h9, 16'h0100, 16'h0300, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 8'd17},
    '{4'h8, 16'h0007, 16'h0064, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17},
    '{4'h8, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 8'd17},
    '{4'h5, 16'h0011, 16'h8001, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'hB, 16'h0004, 16'h1234, 1'b0, 16'h4123, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'hC, 16'h000F, 16'h8000, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
    '{4'h5, 16'h0010, 16'h8001, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
    '{4'hF, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1},
    '{4'hD, 16'h0000, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
    '{4'hE, 16'h0000, 16'h1234, 1'b0, 16'h3412, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'h6, 16'h0001, 16'h0003, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'h0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'h0, 16'h0001, 16'h7FFF, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1},
    '{4'hA, 16'h0014, 16'h1234, 1'b0, 16'h2341, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
    '{4'h9, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17}
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid16;
  logic        in_valid32;
  logic [3:0]  func;
  logic        cin;
  logic [31:0] a_drv;
  logic [31:0] b_drv;

  logic        in_ready16, out_valid16, c16, z16, v16, s16;
  logic [15:0] result16, result_hi16;
  logic        in_ready32, out_valid32, c32, z32, v32, s32;
  logic [31:0] result32, result_hi32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .func      (func),
    .cin       (cin),
    .a         (a_drv[15:0]),
    .b         (b_drv[15:0]),
    .out_valid (out_valid16),
    .result    (result16),
    .result_hi (result_hi16),
    .c         (c16),
    .z         (z16),
    .v         (v16),
    .s         (s16)
  );

  seq_alu #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .func      (func),
    .cin       (cin),
    .a         (a_drv),
    .b         (b_drv),
    .out_valid (out_valid32),
    .result    (result32),
    .result_hi (result_hi32),
    .c         (c32),
    .z         (z32),
    .v         (v32),
    .s         (s32)
  );

  // Two's-complement value of a w-bit quantity.
  function automatic longint sgn(input int w, input u64_t x);
    if (((x >> (w - 1)) & 1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Reference model: the operation table written as integer arithmetic.
  function automatic obs_t model(input int w, input logic [3:0] f,
                                 input u64_t av, input u64_t bv, input logic ci);
    obs_t   o;
    u64_t   mask, t, r;
    longint sa, sb, sr, smax, smin;
    int     n;
    mask = (u64_t'(1) << w) - 1;
    n    = int'(av % u64_t'(w));
    sa   = sgn(w, av);
    sb   = sgn(w, bv);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    o    = '0;
    r    = 0;
    case (f)
      4'h0: begin
        t = bv + av + u64_t'(ci);
        r = t & mask;
        o.c = ((t >> w) & 1) != 0;
        sr = sb + sa + longint'(ci);
        o.v = (sr > smax) || (sr < smin);
      end
      4'h1: begin
        t = bv - av - u64_t'(ci);
        r = t & mask;
        o.c = bv < (av + u64_t'(ci));
        sr = sb - sa - longint'(ci);
        o.v = (sr > smax) || (sr < smin);
      end
      4'h2: r = bv & av;
      4'h3: r = bv | av;
      4'h4: r = bv ^ av;
      4'h5: begin
        r = (bv << n) & mask;
        o.c = (n != 0) && (((bv >> (w - n)) & 1) != 0);
      end
      4'h6: begin
        r = bv >> n;
        o.c = (n != 0) && (((bv >> (n - 1)) & 1) != 0);
      end
      4'h7: r = ~bv & mask;
      4'h8: begin
        if (av == 0) begin
          r = mask;
          o.hi = 32'(bv);
          o.v = 1'b1;
        end else begin
          r = bv / av;
          o.hi = 32'(bv % av);
        end
      end
      4'h9: begin
        t = av * bv;
        r = t & mask;
        o.hi = 32'(t >> w);
        o.v = (t >> w) != 0;
      end
      4'hA: r = (n == 0) ? bv : (((bv << n) | (bv >> (w - n))) & mask);
      4'hB: r = (n == 0) ? bv : (((bv >> n) | (bv << (w - n))) & mask);
      4'hC: begin
        r = u64_t'(sb >>> n) & mask;
        o.c = (n != 0) && (((bv >> (n - 1)) & 1) != 0);
      end
      4'hD: begin
        for (int i = 0; i < w; i++)
          if (((bv >> i) & 1) != 0) r = r | (u64_t'(1) << (w - 1 - i));
      end
      4'hE: begin
        for (int i = 0; i < w / 8; i++)
          r = r | (((bv >> (8 * i)) & 64'hFF) << (8 * (w / 8 - 1 - i)));
      end
      default: r = 0;
    endcase
    o.res = 32'(r);
    o.z   = (r == 0);
    o.s   = ((r >> (w - 1)) & 1) != 0;
    return o;
  endfunction

  // Issue one request to the selected DUT, scramble the inputs right after
  // acceptance, and collect the result, latency, busy behaviour and whether
  // out_valid is a single pulse with the result held afterwards.
  task automatic do_op(input bit wide, input logic [3:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci, output obs_t o,
                       output int lat, output bit busy_ok, output bit pulse_ok);
    obs_t held;
    @(negedge clk);
    func  = f;
    a_drv = av;
    b_drv = bv;
    cin   = ci;
    if (wide) in_valid32 = 1'b1;
    else      in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    func  = 4'($urandom);
    a_drv = $urandom;
    b_drv = $urandom;
    cin   = 1'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    pulse_ok = 1'b0;
    o        = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (wide ? out_valid32 : out_valid16) begin
        lat = k;
        break;
      end
      if (wide ? in_ready32 : in_ready16) busy_ok = 1'b0;
    end
    if (wide) o = '{result32, result_hi32, c32, z32, v32, s32};
    else      o = '{{16'h0, result16}, {16'h0, result_hi16}, c16, z16, v16, s16};
    if (lat != 0) begin
      @(negedge clk);
      if (wide) held = '{result32, result_hi32, c32, z32, v32, s32};
      else      held = '{{16'h0, result16}, {16'h0, result_hi16}, c16, z16, v16, s16};
      pulse_ok = !(wide ? out_valid32 : out_valid16) &&
                 (wide ? in_ready32 : in_ready16) && (held == o);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    func = 4'h0; cin = 1'b0; a_drv = '0; b_drv = '0;
    #12;
    checks++;
    if ({in_ready16, out_valid16, result16, result_hi16, c16, z16, v16, s16} !==
        {1'b1, 1'b0, 32'h0, 4'h0}) begin
      failures++;
      $display("[TB] FAIL reset16 got rdy=%0b ov=%0b res=%h hi=%h czvs=%b%b%b%b",
               in_ready16, out_valid16, result16, result_hi16, c16, z16, v16, s16);
    end
    checks++;
    if ({in_ready32, out_valid32, result32, result_hi32, c32, z32, v32, s32} !==
        {1'b1, 1'b0, 64'h0, 4'h0}) begin
      failures++;
      $display("[TB] FAIL reset32 got rdy=%0b ov=%0b res=%h hi=%h", in_ready32,
               out_valid32, result32, result_hi32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got ov=%0b rdy=%0b expected 0/1",
               out_valid16, in_ready16);
    end
  endtask

  task automatic test_directed();
    obs_t o, e;
    int   lat;
    bit   busy_ok, pulse_ok;
    for (int i = 0; i < NVEC; i++) begin
      do_op(1'b0, VECS[i].f, {16'h0, VECS[i].a}, {16'h0, VECS[i].b}, VECS[i].ci,
            o, lat, busy_ok, pulse_ok);
      e = '{{16'h0, VECS[i].res}, {16'h0, VECS[i].hi},
            VECS[i].c, VECS[i].z, VECS[i].v, VECS[i].s};
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL directed[%0d] got res=%h hi=%h czvs=%b%b%b%b expected res=%h hi=%h czvs=%b%b%b%b",
                 i, o.res, o.hi, o.c, o.z, o.v, o.s, e.res, e.hi, e.c, e.z, e.v, e.s);
      end
      checks++;
      if (lat !== int'(VECS[i].lat)) begin
        failures++;
        $display("[TB] FAIL directed_latency[%0d] got %0d expected %0d", i, lat, VECS[i].lat);
      end
      checks++;
      if (!busy_ok) begin
        failures++;
        $display("[TB] FAIL directed_busy[%0d] in_ready got 1 expected 0 while busy", i);
      end
      checks++;
      if (!pulse_ok) begin
        failures++;
        $display("[TB] FAIL directed_pulse[%0d] out_valid not a single pulse or result not held", i);
      end
    end
  endtask

  task automatic test_random(input bit wide, input int iters);
    obs_t o, e;
    int   lat, w, exp_lat;
    bit   busy_ok, pulse_ok;
    logic [3:0]  f;
    logic [31:0] av, bv;
    logic        ci;
    w = wide ? 32 : 16;
    for (int i = 0; i < iters; i++) begin
      f  = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = $urandom;
      ci = 1'($urandom);
      if ($urandom_range(0, 3) == 0) av = $urandom_range(0, 40);
      if (!wide) begin
        av = {16'h0, av[15:0]};
        bv = {16'h0, bv[15:0]};
      end
      e = model(w, f, u64_t'(av), u64_t'(bv), ci);
      exp_lat = (f == 4'h8 || f == 4'h9) ? w + 1 : 1;
      do_op(wide, f, av, bv, ci, o, lat, busy_ok, pulse_ok);
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL random_w%0d[%0d] f=%h a=%h b=%h cin=%0b got res=%h hi=%h czvs=%b%b%b%b expected res=%h hi=%h czvs=%b%b%b%b",
                 w, i, f, av, bv, ci, o.res, o.hi, o.c, o.z, o.v, o.s,
                 e.res, e.hi, e.c, e.z, e.v, e.s);
      end
      checks++;
      if (lat !== exp_lat || !busy_ok || !pulse_ok) begin
        failures++;
        $display("[TB] FAIL random_timing_w%0d[%0d] got lat=%0d busy_ok=%0b pulse_ok=%0b expected lat=%0d 1 1",
                 w, i, lat, busy_ok, pulse_ok, exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic [3:0]  f;
    logic [31:0] av, bv;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      f  = (k % 2 == 1) ? 4'h4 : 4'h0;
      av = {16'h0, 16'($urandom)};
      bv = {16'h0, 16'($urandom)};
      e  = model(16, f, u64_t'(av), u64_t'(bv), 1'b0);
      func = f; a_drv = av; b_drv = bv; cin = 1'b0;
      in_valid16 = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b1 || result16 !== e.res[15:0] || in_ready16 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_result[%0d] got ov=%0b rdy=%0b res=%h expected ov=1 rdy=0 res=%h",
                 k, out_valid16, in_ready16, result16, e.res[15:0]);
      end
      @(negedge clk);
      checks++;
      if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_gap[%0d] got ov=%0b rdy=%0b expected ov=0 rdy=1",
                 k, out_valid16, in_ready16);
      end
    end
    in_valid16 = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   lat, seen;
    bit   busy_ok, pulse_ok;
    do_op(1'b0, 4'h7, 32'h0, 32'h0, 1'b0, o, lat, busy_ok, pulse_ok);
    @(negedge clk);
    func = 4'h9; a_drv = 32'h0000_0100; b_drv = 32'h0000_0300; cin = 1'b0;
    in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready16, out_valid16, result16, result_hi16, c16, z16, v16, s16} !==
        {1'b1, 1'b0, 32'h0, 4'h0}) begin
      failures++;
      $display("[TB] FAIL reset_mid_async got rdy=%0b ov=%0b res=%h hi=%h czvs=%b%b%b%b expected 1 0 0 0 0000",
               in_ready16, out_valid16, result16, result_hi16, c16, z16, v16, s16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid16) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_valid got %0d pulses expected 0", seen);
    end
    do_op(1'b0, 4'h0, 32'd3, 32'd2, 1'b0, o, lat, busy_ok, pulse_ok);
    checks++;
    if (o.res !== 32'd5 || lat !== 1) begin
      failures++;
      $display("[TB] FAIL reset_mid_add got res=%h lat=%0d expected res=0005 lat=1", o.res, lat);
    end
  endtask

  task automatic test_width32();
    obs_t o;
    int   lat;
    bit   busy_ok, pulse_ok;
    do_op(1'b1, 4'h0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, o, lat, busy_ok, pulse_ok);
    checks++;
    if (o !== obs_t'({32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0}) || lat !== 1) begin
      failures++;
      $display("[TB] FAIL w32_add_carry got res=%h c=%0b z=%0b v=%0b s=%0b lat=%0d expected 0 1 1 0 0 1",
               o.res, o.c, o.z, o.v, o.s, lat);
    end
    do_op(1'b1, 4'h0, 32'd3, 32'd2, 1'b0, o, lat, busy_ok, pulse_ok);
    checks++;
    if (o.res !== 32'd5 || o.z !== 1'b0 || lat !== 1) begin
      failures++;
      $display("[TB] FAIL w32_add got res=%h lat=%0d expected 5 1", o.res, lat);
    end
    test_random(1'b1, 24);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 150);
    test_back_to_back();
    test_reset_mid();
    test_width32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
